// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN input loader.
package snn_pkg;
    localparam int NUM_PIXELS    = 784;
    localparam int BYTES_PER_IMG = 98;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } loader_state_t;
endpackage

// File: rtl/pixel_buf.sv
// Byte-wide image store with a registered, bit-selected 1-bit read port.
module pixel_buf #(
    parameter int DEPTH      = 98,
    parameter int NUM_PIXELS = 784
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [9:0] raddr,
    output logic       q
);
    logic [7:0] mem [DEPTH];

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (raddr < 10'(NUM_PIXELS)) begin
            q <= mem[raddr[9:3]][raddr[2:0]];
        end else begin
            q <= 1'b0;
        end
    end
endmodule

// File: rtl/snn_input_loader.sv
// Buffers a UART-delivered binary image, kicks the SNN core and serves its pixel reads.
//
//   state | meaning
//   LOAD  | accepting image bytes from the UART
//   START | one-cycle start pulse to the core
//   RUN   | inference in flight, waiting for done
module snn_input_loader #(
    parameter int NUM_PIXELS    = snn_pkg::NUM_PIXELS,
    parameter int BYTES_PER_IMG = snn_pkg::BYTES_PER_IMG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       done,
    output logic       busy,
    output logic       overrun,
    output logic [6:0] byte_cnt
);
    import snn_pkg::*;

    localparam logic [6:0] LAST_BYTE = 7'(BYTES_PER_IMG - 1);

    loader_state_t state_q, state_d;
    logic          wr_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (rx_rdy && byte_cnt == LAST_BYTE) state_d = START;
            START:   state_d = RUN;
            RUN:     if (done) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    assign wr_en = (state_q == LOAD) && rx_rdy;
    assign start = (state_q == START);
    assign busy  = (state_q == START) || (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            byte_cnt <= 7'd0;
            overrun  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                byte_cnt <= byte_cnt + 7'd1;
            end else if (state_q == RUN && done) begin
                byte_cnt <= 7'd0;
            end
            // A strobe coincident with done in RUN is still dropped.
            if (rx_rdy && state_q != LOAD) begin
                overrun <= 1'b1;
            end else if (wr_en && byte_cnt == 7'd0) begin
                overrun <= 1'b0;
            end
        end
    end

    pixel_buf #(
        .DEPTH      (BYTES_PER_IMG),
        .NUM_PIXELS (NUM_PIXELS)
    ) u_pixel_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (byte_cnt),
        .wdata (rx_data),
        .raddr (addr_input_unit),
        .q     (q_input)
    );
endmodule

// File: tb/tb_snn_input_loader.sv
// Scoreboard bench for snn_input_loader: stimulus queues expectations, a negedge monitor retires them.
module tb_snn_input_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] addr_input_unit = 10'd0;
    logic       q_input;
    logic       start;
    logic       done = 1'b0;
    logic       busy;
    logic       overrun;
    logic [6:0] byte_cnt;

    localparam int SIG_Q = 0, SIG_START = 1, SIG_BUSY = 2, SIG_OVR = 3, SIG_CNT = 4;

    typedef struct {
        int    due;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    snn_input_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_rdy          (rx_rdy),
        .rx_data         (rx_data),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .start           (start),
        .done            (done),
        .busy            (busy),
        .overrun         (overrun),
        .byte_cnt        (byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                int act;
                case (sb[i].sig)
                    SIG_Q:     act = int'(q_input);
                    SIG_START: act = int'(start);
                    SIG_BUSY:  act = int'(busy);
                    SIG_OVR:   act = int'(overrun);
                    default:   act = int'(byte_cnt);
                endcase
                checks++;
                if (sb[i].due != cyc || act != sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)",
                             sb[i].name, act, sb[i].exp, cyc, sb[i].due);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int d, input int sig, input int exp, input string name);
        exp_t e;
        e.due  = cyc + d;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Streams n bytes back-to-back; base is the byte count before the first one.
    task automatic load_bytes(input logic [7:0] b, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            int cnt;
            cnt     = base + i + 1;
            rx_rdy  = 1'b1;
            rx_data = b;
            expect_at(1, SIG_CNT, cnt, "byte_cnt_load");
            expect_at(1, SIG_START, (cnt == 98) ? 1 : 0, "start_load");
            expect_at(1, SIG_BUSY, (cnt == 98) ? 1 : 0, "busy_load");
            if (cnt == 98) begin
                expect_at(2, SIG_START, 0, "start_single_pulse");
                expect_at(2, SIG_BUSY, 1, "busy_run");
                expect_at(2, SIG_CNT, 98, "byte_cnt_hold");
            end
            @(negedge clk);
        end
        rx_rdy = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] b, input int lo, input int hi);
        for (int p = lo; p <= hi; p++) begin
            addr_input_unit = 10'(p);
            expect_at(1, SIG_Q, (p < 784) ? int'(b[p % 8]) : 0, "q_sweep");
            @(negedge clk);
        end
    endtask

    task automatic read_px(input int a, input int exp, input string name);
        addr_input_unit = 10'(a);
        expect_at(1, SIG_Q, exp, name);
        @(negedge clk);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expect_at(1, SIG_CNT, 0, "rst_byte_cnt");
        expect_at(1, SIG_START, 0, "rst_start");
        expect_at(1, SIG_BUSY, 0, "rst_busy");
        expect_at(1, SIG_OVR, 0, "rst_overrun");
        expect_at(1, SIG_Q, 0, "rst_q");
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(1, SIG_START, 0, "post_rst_start");
        expect_at(1, SIG_CNT, 0, "post_rst_cnt");
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Frame of 0xA5, then full pixel sweep and out-of-range reads.
        load_bytes(8'hA5, 98, 0);
        sweep(8'hA5, 0, 783);
        read_px(784, 0, "q_addr_784");
        read_px(1023, 0, "q_addr_1023");

        // Byte during RUN is dropped and flags overrun.
        rx_rdy  = 1'b1;
        rx_data = 8'hFF;
        expect_at(1, SIG_OVR, 1, "overrun_set");
        expect_at(1, SIG_CNT, 98, "cnt_overrun_hold");
        @(negedge clk);
        rx_rdy = 1'b0;
        read_px(1, 0, "buf_unchanged_px1");
        read_px(0, 1, "buf_unchanged_px0");

        expect_at(1, SIG_BUSY, 0, "busy_after_done");
        expect_at(1, SIG_CNT, 0, "cnt_after_done");
        expect_at(1, SIG_OVR, 1, "overrun_sticky");
        pulse_done();

        rx_rdy  = 1'b1;
        rx_data = 8'h3C;
        expect_at(1, SIG_OVR, 0, "overrun_clear");
        expect_at(1, SIG_CNT, 1, "cnt_first_byte");
        @(negedge clk);
        rx_rdy = 1'b0;
        read_px(2, 1, "px2_new_byte");
        read_px(1, 0, "px1_new_byte");

        // done in LOAD is ignored.
        load_bytes(8'h11, 19, 1);
        expect_at(1, SIG_CNT, 20, "done_in_load_cnt");
        expect_at(1, SIG_BUSY, 0, "done_in_load_busy");
        pulse_done();

        // Partial frame abandoned by reset.
        load_bytes(8'h22, 30, 20);
        do_reset();
        expect_at(1, SIG_START, 0, "no_start_after_rst");
        @(negedge clk);

        load_bytes(8'h5A, 98, 0);
        read_px(0, 0, "px0_5a");
        read_px(1, 1, "px1_5a");
        read_px(783, 0, "px783_5a");
        pulse_done();

        // Second frame of zeros.
        load_bytes(8'h00, 98, 0);
        sweep(8'h00, 0, 783);

        // rx_rdy coincident with done in RUN is discarded.
        rx_rdy  = 1'b1;
        rx_data = 8'hFF;
        done    = 1'b1;
        expect_at(1, SIG_OVR, 1, "overrun_coincident");
        expect_at(1, SIG_CNT, 0, "cnt_coincident");
        expect_at(1, SIG_BUSY, 0, "busy_coincident");
        @(negedge clk);
        done    = 1'b0;
        rx_data = 8'h01;
        expect_at(1, SIG_CNT, 1, "cnt_after_coincident");
        expect_at(1, SIG_OVR, 0, "overrun_clr_after_coincident");
        @(negedge clk);
        rx_rdy = 1'b0;
        read_px(0, 1, "px0_after_coincident");
        read_px(8, 0, "px8_untouched");

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
